// File: rtl/frame_fill_engine.sv
// frame_fill_engine: renders one 32x24 3:3:2 frame (gradient plus bouncing
// box) into the back buffer, one write beat per ce-qualified clock.
module frame_fill_engine #(
    parameter int         COLS      = 32,
    parameter int         ROWS      = 24,
    parameter int         BOX_W     = 6,
    parameter int         BOX_H     = 4,
    parameter logic [7:0] BOX_COLOR = 8'hFF,
    parameter int         ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_btn,
    input  logic              ce,
    input  logic              frame_start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic [4:0]        box_x,
    output logic [4:0]        box_y
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [4:0] X_MAX    = 5'(COLS - BOX_W);
    localparam logic [4:0] Y_MAX    = 5'(ROWS - BOX_H);
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [5:0] BOX_W6   = 6'(BOX_W);
    localparam logic [5:0] BOX_H6   = 6'(BOX_H);

    state_t r_state;
    state_t w_next;

    logic [4:0]        r_col;
    logic [4:0]        r_row;
    logic [4:0]        r_box_x;
    logic [4:0]        r_box_y;
    logic              r_dx;  // 1: moving +1, 0: moving -1
    logic              r_dy;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_overrun;

    logic       w_beat;
    logic       w_last;
    logic       w_in_box;
    logic [5:0] w_col6;
    logic [5:0] w_row6;
    logic [5:0] w_bx6;
    logic [5:0] w_by6;
    logic [7:0] w_pixel;

    assign w_beat = (r_state == S_FILL) && ce;
    assign w_last = (r_col == LAST_COL) && (r_row == LAST_ROW);

    // 6-bit compares so box_x + BOX_W cannot wrap
    assign w_col6 = {1'b0, r_col};
    assign w_row6 = {1'b0, r_row};
    assign w_bx6  = {1'b0, r_box_x};
    assign w_by6  = {1'b0, r_box_y};

    assign w_in_box = (w_col6 >= w_bx6) && (w_col6 < w_bx6 + BOX_W6)
                   && (w_row6 >= w_by6) && (w_row6 < w_by6 + BOX_H6);

    assign w_pixel = w_in_box ? BOX_COLOR
                              : {r_col[4:2], r_row[4:2], 2'b00};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (frame_start) w_next = S_MOVE;
            S_MOVE: w_next = S_FILL;
            S_FILL: if (ce && w_last) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_btn) begin
        if (rst_btn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst_btn) begin
        if (rst_btn) begin
            r_col     <= 5'd0;
            r_row     <= 5'd0;
            r_box_x   <= 5'd0;
            r_box_y   <= 5'd0;
            r_dx      <= 1'b1;
            r_dy      <= 1'b1;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'd0;
            r_overrun <= 1'b0;
        end else begin
            r_wr_en <= w_beat;
            if (frame_start && (r_state != S_IDLE))
                r_overrun <= 1'b1;
            if (r_state == S_MOVE) begin
                r_col <= 5'd0;
                r_row <= 5'd0;
                if (r_dx) begin
                    if (r_box_x == X_MAX) begin
                        r_dx    <= 1'b0;
                        r_box_x <= r_box_x - 5'd1;
                    end else begin
                        r_box_x <= r_box_x + 5'd1;
                    end
                end else if (r_box_x == 5'd0) begin
                    r_dx    <= 1'b1;
                    r_box_x <= 5'd1;
                end else begin
                    r_box_x <= r_box_x - 5'd1;
                end
                if (r_dy) begin
                    if (r_box_y == Y_MAX) begin
                        r_dy    <= 1'b0;
                        r_box_y <= r_box_y - 5'd1;
                    end else begin
                        r_box_y <= r_box_y + 5'd1;
                    end
                end else if (r_box_y == 5'd0) begin
                    r_dy    <= 1'b1;
                    r_box_y <= 5'd1;
                end else begin
                    r_box_y <= r_box_y - 5'd1;
                end
            end
            if (w_beat) begin
                r_wr_addr <= ADDR_W'({r_row, r_col});
                r_wr_data <= w_pixel;
                if (r_col == LAST_COL) begin
                    r_col <= 5'd0;
                    r_row <= r_row + 5'd1;
                end else begin
                    r_col <= r_col + 5'd1;
                end
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_DONE);
    assign overrun    = r_overrun;
    assign box_x      = r_box_x;
    assign box_y      = r_box_y;

endmodule
